// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter driving a shared 3-to-8 one-hot decoder bank.
// Break-before-make between tenures, with an optional per-tenure hold limit.
module rr_decoder_arbiter #(
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned N_REQ    = 8,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic             tmo,
  output logic [CNT_W-1:0] busy_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [SEL_W-1:0] PTR_RST  = SEL_W'(N_REQ - 1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             en_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic             tmo_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [SEL_W-1:0] win;
  logic             nrm_rls;
  logic             frc_rls;

  // Winner search: descending scan so the nearest requester after ptr wins last.
  always_comb begin
    win = ptr;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[ptr + SEL_W'(i)]) begin
        win = ptr + SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= PTR_RST;
      sel      <= '0;
      en       <= 1'b0;
      gnt      <= '0;
      tmo      <= 1'b0;
      busy_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      sel      <= sel_nxt;
      en       <= en_nxt;
      gnt      <= gnt_nxt;
      tmo      <= tmo_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Normal release outranks the hold limit, so tmo only marks a pure timeout.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    en_nxt    = en;
    gnt_nxt   = gnt;
    tmo_nxt   = 1'b0;
    cnt_nxt   = busy_cnt;
    nrm_rls   = 1'b0;
    frc_rls   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          sel_nxt   = win;
          en_nxt    = 1'b1;
          gnt_nxt   = N_REQ'(1) << win;
          cnt_nxt   = CNT_W'(1);
        end
      end
      GRANT: begin
        nrm_rls = rel | ~req[sel];
        frc_rls = (MAX_HOLD != 0) && (busy_cnt == HOLD_LIM);
        if (nrm_rls || frc_rls) begin
          state_nxt = IDLE;
          ptr_nxt   = sel;
          en_nxt    = 1'b0;
          gnt_nxt   = '0;
          cnt_nxt   = '0;
          tmo_nxt   = ~nrm_rls;
        end else if (busy_cnt != CNT_MAX) begin
          cnt_nxt = busy_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Round-robin arbiter that shares one 3-to-8 one-hot decoder output bank between 8 requesters.
- Picks a requester and drives the decoder's select index and enable, so exactly one grant line is high.
- Enforces break-before-make between grants and limits how long one requester can hold the grant.
- Sits between the request sources and the decoder's chip-select/enable outputs.

Parameters:
- SEL_W, 3, select index width.
- N_REQ, 8, number of requesters. Must equal 2**SEL_W.
- MAX_HOLD, 4, maximum consecutive grant cycles per tenure. 0 = unlimited.
- CNT_W, 8, hold counter width. Must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  request vector, level-sensitive, bit i = requester i
- rel  input  1  single-cycle release strobe from the current grantee
- sel  output  SEL_W  registered decoder select index
- en  output  1  registered decoder enable; high only while a grant is active
- gnt  output  N_REQ  registered one-hot grant, equal to decode(sel) when en=1, else 0
- tmo  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD
- busy_cnt  output  CNT_W  cycles elapsed in the current tenure; 0 when idle

Behaviour:
- Single clock domain. All outputs are registered.
- Reset: rst_n low clears asynchronously, regardless of clock:
  - sel=0, en=0, gnt=0, tmo=0, busy_cnt=0.
  - Last-grant pointer ptr=N_REQ-1, so requester 0 has top priority after reset.
  - State=IDLE.
- Reset deassertion is synchronised by the system. The first active edge evaluates from IDLE.
- States: IDLE, GRANT.
- IDLE:
  - If req==0: stay in IDLE, outputs unchanged (en=0, gnt=0).
  - Else choose winner w = first set bit of req, scanning ptr+1, ptr+2, … modulo N_REQ (wraps from N_REQ-1 to 0).
  - At the same edge: sel<=w, en<=1, gnt<=onehot(w), busy_cnt<=1, state<=GRANT.
  - Latency: req sampled at edge k gives gnt visible after edge k.
- GRANT, evaluated every edge, release conditions in priority order:
  - a) rel=1, or req[sel]=0: normal release.
  - b) MAX_HOLD!=0 and busy_cnt==MAX_HOLD: forced release, tmo<=1 for one cycle.
  - On any release: en<=0, gnt<=0, busy_cnt<=0, ptr<=sel, state<=IDLE. sel holds its last value.
  - Otherwise: busy_cnt<=busy_cnt+1. With MAX_HOLD=0 it saturates at all-ones and never wraps.
- Break-before-make: every release is followed by at least one cycle with en=0 and gnt=0 before any new grant. Grant-to-grant spacing is at least 1 idle cycle.
- Simultaneous events:
  - rel with timeout on the same edge: normal release, tmo stays 0.
  - Request drop with timeout on the same edge: normal release, tmo stays 0.
  - Changes to other req bits during GRANT are ignored until the next IDLE evaluation.
  - rel while in IDLE is ignored.
- Fairness: the just-released requester has lowest priority at the next arbitration. With all 8 requesting, grants cycle 0,1,…,7,0…
- Invariants, checked every cycle:
  - popcount(gnt) <= 1.
  - gnt != 0 if and only if en=1.
  - When en=1, gnt == 1<<sel.
  - tmo is high for at most 1 cycle and only in the cycle after en falls.
- Reset mid-grant: en and gnt drop immediately (asynchronously), and ptr returns to N_REQ-1.

Test Plan:
- Reset, then req=8'b0000_0100 held, rel=0 -> next edge sel=2, en=1, gnt=8'h04; busy_cnt counts 1..4; after the 4th grant cycle en=0, gnt=0, tmo=1 for 1 cycle; one cycle later gnt=8'h04 again.
- req=8'hFF held, each grantee pulses rel on its 2nd grant cycle -> gnt sequence 01,02,04,…,80,01, each active 2 cycles and separated by exactly 1 idle cycle; tmo never asserts.
- Grant held by 5 (req=8'h21), rel=1 on the same edge busy_cnt reaches 4 -> release, tmo=0; next grant goes to 0 (wrap from 5 past 6, 7).
- req=8'h08 granted, then req[3] drops mid-tenure while req[1] rises -> en falls on that edge, 1 idle cycle, then gnt=8'h02.
- MAX_HOLD=0 instance, req=8'h80 held for 300 cycles -> gnt=8'h80 continuously, busy_cnt saturates at 255, tmo=0.
- rst_n pulsed low between clock edges during an active grant of 6 -> en, gnt and busy_cnt go to 0 without a clock edge; after release with req=8'h41, the first grant goes to 0.
